// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host blocks
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_START_TMO = 2'b01,
    ERR_PKT_TMO   = 2'b10,
    ERR_NACK      = 2'b11
  } err_e;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchroniser plus falling-edge detect for one PS/2 line
`timescale 1ns/1ps
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resynchronise the open-drain line; flops reset high (idle bus) so no fake fall after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int INHIBIT_US   = 100,
  parameter int START_TMO_US = 15000,
  parameter int PKT_TMO_US   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       clk_oe,
  output logic       data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CYC_PER_US    = CLK_FREQ_HZ / 1_000_000;
  localparam int INHIBIT_CYC   = CYC_PER_US * INHIBIT_US;
  localparam int START_TMO_CYC = CYC_PER_US * START_TMO_US;
  localparam int PKT_TMO_CYC   = CYC_PER_US * PKT_TMO_US;
  localparam int MAX_AB        = (INHIBIT_CYC > START_TMO_CYC) ? INHIBIT_CYC : START_TMO_CYC;
  localparam int MAX_CYC       = (MAX_AB > PKT_TMO_CYC) ? MAX_AB : PKT_TMO_CYC;
  localparam int CNT_W         = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] INH_PRE    = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PKT_TMO_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shreg_q, shreg_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  err_e             err_code_q, err_code_d;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (ps2_clk_in),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (ps2_data_in),
    .sync_o (data_sync),
    .fall_o (data_fall_unused)
  );

  // State, counters and registered line drivers; reset releases the bus at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pkt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic: line values only change on the cycle a device fall is seen
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pkt_d      = pkt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shreg_d    = {1'b1, odd_parity(tx_data), tx_data};
          err_code_d = ERR_NONE;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          clk_oe_d   = 1'b1;
          state_d    = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = START;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          // Start bit is asserted one cycle before the clock is let go
          if (cnt_q == INH_PRE) begin
            data_oe_d = 1'b1;
          end
        end
      end

      START: begin
        if (clk_fall) begin
          data_oe_d = ~shreg_q[0];
          bit_cnt_d = 4'd1;
          pkt_d     = '0;
          state_d   = SHIFT;
        end else if (cnt_q == START_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_START_TMO;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end

      SHIFT: begin
        pkt_d = (pkt_q == CNT_MAX) ? pkt_q : pkt_q + CNT_ONE;
        if (clk_fall) begin
          data_oe_d = ~shreg_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = ACK;
          end
        end else if (pkt_q == PKT_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_PKT_TMO;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          state_d    = IDLE;
        end
      end

      ACK: begin
        pkt_d = (pkt_q == CNT_MAX) ? pkt_q : pkt_q + CNT_ONE;
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            state_d    = IDLE;
          end
        end else if (pkt_q == PKT_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_PKT_TMO;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          state_d    = IDLE;
        end
      end

      WAIT_IDLE: begin
        pkt_d = (pkt_q == CNT_MAX) ? pkt_q : pkt_q + CNT_ONE;
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (pkt_q == PKT_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_PKT_TMO;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign clk_oe   = clk_oe_q;
  assign data_oe  = data_oe_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (for example 0xF4 "enable reporting" or 0xFF "reset") to the mouse on the shared ps2_clk/ps2_data open-drain pair.
- It is the transmit counterpart of the mouse packet receiver and runs on the 100 MHz mclk domain.
- The top level ties the lines as: ps2_clk = clk_oe ? 0 : z, and ps2_data = data_oe ? 0 : z.
- The block owns the bus only while busy. A receiver must ignore the lines whenever busy=1.

Parameters:
- CLK_FREQ_HZ, 100_000_000: frequency of clk.
- INHIBIT_US, 100: time clk_oe holds the clock line low before the start bit.
- START_TMO_US, 15000: maximum wait from clock release to the first device falling edge.
- PKT_TMO_US, 2000: maximum time from the first falling edge to the ACK edge.

Ports:
- clk, in, 1: system clock (mclk).
- rst, in, 1: asynchronous, active-low reset.
- tx_data, in, 8: command byte.
- tx_valid, in, 1: request to send tx_data.
- tx_ready, out, 1: high only in IDLE. The transfer is accepted when tx_valid & tx_ready.
- ps2_clk_in, in, 1: raw clock line, asynchronous.
- ps2_data_in, in, 1: raw data line, asynchronous.
- clk_oe, out, 1: 1 = pull the clock line low.
- data_oe, out, 1: 1 = pull the data line low.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when the device ACK is received.
- err, out, 1: one-cycle pulse when a transfer aborts.
- err_code, out, 2: cause of the abort. 01 = start timeout, 10 = packet timeout, 11 = no ACK. Held until the next accept.

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE.
  - clk_oe=0, data_oe=0, tx_ready=1, busy=0, done=0, err=0, err_code=00.
  - A reset mid-transfer releases both lines immediately.
- Input conditioning:
  - Two-flop synchroniser on each line, plus one history flop.
  - fall = prev & ~cur, giving a 3-cycle detection latency.
- Accept:
  - On tx_valid & tx_ready, latch the shift register {stop=1, parity, tx_data}.
  - parity = ~^tx_data (odd parity).
  - Clear err_code, go to INHIBIT.
  - tx_valid while busy is ignored; no queueing.
- INHIBIT:
  - clk_oe=1 for exactly INHIBIT_CYC = CLK_FREQ_HZ/1e6*INHIBIT_US cycles (10000 at default).
  - data_oe goes to 1 in the last inhibit cycle.
  - Then go to START.
- START:
  - clk_oe=0 (clock released), data_oe=1 (start bit).
  - Start timeout counter runs. On the first fall, drive D0 and set bit_cnt=1, go to SHIFT.
  - If START_TMO cycles pass with no fall: err=1, err_code=01, release both lines, go to IDLE.
- SHIFT:
  - On each fall, drive the next bit, with data_oe = ~bit.
  - Falls 2..8 drive D1..D7, fall 9 drives parity, fall 10 drives stop (data_oe=0).
  - bit_cnt increments once per fall. After fall 10, go to ACK.
  - Data changes only on the cycle fall is seen, never otherwise.
- ACK:
  - On fall 11, sample the synchronised data line.
  - 0: go to WAIT_IDLE.
  - 1: err=1, err_code=11, go to IDLE.
- Packet timeout:
  - Counter starts at fall 1 and spans SHIFT and ACK.
  - If it exceeds PKT_TMO cycles (200000 at default) before fall 11: err, err_code=10, release both lines, go to IDLE.
- WAIT_IDLE:
  - Wait until both synchronised lines are 1.
  - Then pulse done=1 for one cycle and go to IDLE. tx_ready rises on the same cycle as done.
  - The PKT_TMO counter continues here. On expiry: err_code=10.
- Pulses: done and err are mutually exclusive, both one cycle wide.
- Counter widths:
  - Sized with $clog2 of the largest count (21 bits for START_TMO at default).
  - Counters saturate and never wrap.
  - bit_cnt is 4 bits.
- Line glitches: a fall in IDLE or INHIBIT is ignored.

Decomposition:
- Package ps2_pkg holds:
  - State enum: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
  - Error codes: ERR_NONE, ERR_START_TMO, ERR_PKT_TMO, ERR_NACK.
  - Command constants: CMD_RESET=0xFF, CMD_ENABLE=0xF4, RSP_ACK=0xFA.
- Sub-module ps2_line_sync: two-flop synchroniser plus falling-edge detector for one line. It is instantiated twice and is reusable by the receiver.

Test Plan:
- Send 0xF4; device model clocks at 12.5 kHz and ACKs.
  - clk_oe low for 10000 cycles; line bits after start are 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - done pulses once; err_code=00.
- Send 0xFF and 0x00: parity driven is 1 in both cases. Send 0x01: parity 0.
- Device never clocks after release: err pulses 1,500,000 cycles after START entry; err_code=01; clk_oe=data_oe=0.
- Device leaves data high at the 11th edge: err pulse, err_code=11, no done.
- Device stops clocking after 5 falls: err_code=10, 200000 cycles after fall 1; lines released; tx_ready=1.
- Reset mid-transfer:
  - Assert rst=0 during SHIFT with bit_cnt=4: clk_oe=data_oe=0 asynchronously, outputs hold reset values.
  - tx_valid pulsed during busy is ignored.
  - After reset release, a new 0xF4 completes normally.
